packet_egress_buffer: RTL and testbench

Store-and-forward packet buffer placed directly downstream of the two-channel transport packet arbiter; it accepts the arbitrated beat stream (head, data, start, last) and releases a packet to the egress link only once its last beat has been stored. It decouples the arbiter from link back-pressure, so an arbitrated channel is never stalled by a half-sent packet. It also checks start/last framing.

---
 rtl/packet_egress_buffer_pkg.sv | 24 ++
 rtl/packet_egress_buffer_if.sv | 34 +++
 rtl/sync_fifo_show_ahead.sv | 47 ++++
 rtl/packet_egress_buffer.sv | 106 ++++++++++
 tb/tb_packet_egress_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_egress_buffer_pkg.sv
// Shared widths, default depths and payload types for the packet egress buffer.
// PKT_EGRESS_CUT_THROUGH_EN (optional macro) selects cut-through release in the top.
package packet_egress_buffer_pkg;

  localparam int unsigned PKT_HEAD_WIDTH        = 8;
  localparam int unsigned PKT_DATA_WIDTH        = 32;
  localparam int unsigned PKT_EGRESS_DATA_DEPTH = 64;
  localparam int unsigned PKT_EGRESS_HEAD_DEPTH = 8;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BODY = 1'b1
  } rx_state_e;

  // One stored data-FIFO entry.
  typedef struct packed {
    logic [PKT_DATA_WIDTH-1:0] data;
    logic                      start;
    logic                      last;
  } beat_t;

  localparam int unsigned BEAT_WIDTH = $bits(beat_t);

endpackage

// File: rtl/packet_egress_buffer_if.sv
// Beat-stream bundle between the arbiter, the egress buffer and the egress link.
interface packet_egress_buffer_if #(
  parameter int unsigned CNT_WIDTH = 4
);
  import packet_egress_buffer_pkg::*;

  logic                      i_pkt_valid;
  logic [PKT_HEAD_WIDTH-1:0] iv_pkt_head;
  logic [PKT_DATA_WIDTH-1:0] iv_pkt_data;
  logic                      i_pkt_start;
  logic                      i_pkt_last;
  logic                      o_pkt_ready;
  logic                      o_out_valid;
  logic [PKT_HEAD_WIDTH-1:0] ov_out_head;
  logic [PKT_DATA_WIDTH-1:0] ov_out_data;
  logic                      o_out_start;
  logic                      o_out_last;
  logic                      i_out_ready;
  logic                      o_frame_err;
  logic [CNT_WIDTH-1:0]      ov_pkt_cnt;

  modport slave (
    input  i_pkt_valid, iv_pkt_head, iv_pkt_data, i_pkt_start, i_pkt_last, i_out_ready,
    output o_pkt_ready, o_out_valid, ov_out_head, ov_out_data, o_out_start, o_out_last,
           o_frame_err, ov_pkt_cnt
  );

  modport master (
    output i_pkt_valid, iv_pkt_head, iv_pkt_data, i_pkt_start, i_pkt_last, i_out_ready,
    input  o_pkt_ready, o_out_valid, ov_out_head, ov_out_data, o_out_start, o_out_last,
           o_frame_err, ov_pkt_cnt
  );

endinterface

// File: rtl/sync_fifo_show_ahead.sv
// Single-clock FIFO whose head entry is visible on dout without a read strobe.
module sync_fifo_show_ahead #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/packet_egress_buffer.sv
// Store-and-forward egress buffer with start/last framing check.
// Define PKT_EGRESS_CUT_THROUGH_EN to release beats as soon as they are stored.
module packet_egress_buffer
  import packet_egress_buffer_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = PKT_EGRESS_DATA_DEPTH,
  parameter int unsigned HEAD_DEPTH = PKT_EGRESS_HEAD_DEPTH
) (
  input logic                   clk,
  input logic                   rst,
  packet_egress_buffer_if.slave bus
);
  localparam int unsigned DATA_CNT_WIDTH = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned HEAD_CNT_WIDTH = $clog2(HEAD_DEPTH) + 1;

  rx_state_e                 state;
  logic                      rdy_en;
  logic                      frame_err;
  logic [HEAD_CNT_WIDTH-1:0] pkt_cnt;

  logic                      d_full, d_empty, h_full, h_empty;
  logic [DATA_CNT_WIDTH-1:0] d_count;
  logic [HEAD_CNT_WIDTH-1:0] h_count;
  beat_t                     d_din, d_dout;
  logic [PKT_HEAD_WIDTH-1:0] h_dout;
  logic                      unused_fifo_status;

  logic idle_c, ready_c, acc_c, d_wr_c, h_wr_c, commit_c, bad_c;
  logic out_valid_c, pop_c, pop_last_c;

  assign idle_c   = (state == RX_IDLE);
  assign ready_c  = rdy_en & ~d_full & (~h_full | ~bus.i_pkt_start | ~idle_c);
  assign acc_c    = bus.i_pkt_valid & ready_c;
  // Headless beats in IDLE are swallowed; everything else is stored.
  assign d_wr_c   = acc_c & ~(idle_c & ~bus.i_pkt_start);
  assign h_wr_c   = acc_c & idle_c & bus.i_pkt_start;
  assign commit_c = d_wr_c & bus.i_pkt_last;
  assign bad_c    = acc_c & (idle_c ^ bus.i_pkt_start);
  assign d_din    = '{data: bus.iv_pkt_data, start: bus.i_pkt_start & idle_c, last: bus.i_pkt_last};

`ifdef PKT_EGRESS_CUT_THROUGH_EN
  assign out_valid_c = ~d_empty & ~h_empty;
`else
  assign out_valid_c = (pkt_cnt != '0);
`endif
  assign pop_c      = out_valid_c & bus.i_out_ready;
  assign pop_last_c = pop_c & d_dout.last;

  assign unused_fifo_status = ^{d_count, h_count, d_empty, h_empty};

  sync_fifo_show_ahead #(.WIDTH(BEAT_WIDTH), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (d_wr_c),
    .din   (d_din),
    .full  (d_full),
    .rd_en (pop_c),
    .dout  (d_dout),
    .empty (d_empty),
    .count (d_count)
  );

  sync_fifo_show_ahead #(.WIDTH(PKT_HEAD_WIDTH), .DEPTH(HEAD_DEPTH)) u_head_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (h_wr_c),
    .din   (bus.iv_pkt_head),
    .full  (h_full),
    .rd_en (pop_last_c),
    .dout  (h_dout),
    .empty (h_empty),
    .count (h_count)
  );

  // RX framing FSM, committed-packet counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      rdy_en    <= 1'b0;
      frame_err <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      rdy_en    <= 1'b1;
      frame_err <= bad_c;
      if (acc_c) begin
        case (state)
          RX_IDLE: if (bus.i_pkt_start && !bus.i_pkt_last) state <= RX_BODY;
          RX_BODY: if (bus.i_pkt_last) state <= RX_IDLE;
          default: state <= RX_IDLE;
        endcase
      end
      if (commit_c && !pop_last_c) pkt_cnt <= pkt_cnt + HEAD_CNT_WIDTH'(1);
      else if (!commit_c && pop_last_c) pkt_cnt <= pkt_cnt - HEAD_CNT_WIDTH'(1);
    end
  end

  assign bus.o_pkt_ready = ready_c;
  assign bus.o_out_valid = out_valid_c;
  assign bus.ov_out_head = out_valid_c ? h_dout : '0;
  assign bus.ov_out_data = out_valid_c ? d_dout.data : '0;
  assign bus.o_out_start = out_valid_c & d_dout.start;
  assign bus.o_out_last  = out_valid_c & d_dout.last;
  assign bus.o_frame_err = frame_err;
  assign bus.ov_pkt_cnt  = pkt_cnt;

endmodule

// File: tb/tb_packet_egress_buffer.sv
// Randomized bench for packet_egress_buffer against a packet-level queue model.
module tb_packet_egress_buffer;
  import packet_egress_buffer_pkg::*;

  localparam int unsigned DD = 64;
  localparam int unsigned HD = 8;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [PKT_HEAD_WIDTH-1:0] head;
    logic [PKT_DATA_WIDTH-1:0] data;
    logic                      start;
    logic                      last;
  } mbeat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_egress_buffer_if #(.CNT_WIDTH(CW)) bus();

  packet_egress_buffer #(.DATA_DEPTH(DD), .HEAD_DEPTH(HD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: beats releasable to the link, beats of the open packet,
  // heads held (one per packet not yet fully sent) and complete packets held.
  mbeat_t                    out_q[$];
  mbeat_t                    pend_q[$];
  int                        heads;
  int                        pkts;
  bit                        in_pkt;
  bit                        rdy_ok;
  bit                        exp_err;
  logic [PKT_HEAD_WIDTH-1:0] cur_head;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    out_q.delete();
    pend_q.delete();
    heads   = 0;
    pkts    = 0;
    in_pkt  = 1'b0;
    rdy_ok  = 1'b0;
    exp_err = 1'b0;
    cur_head = '0;
  endtask

  function automatic bit ordy_of(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(99) < 70);
  endfunction

  // One clock cycle: drive at negedge, check just after, update model, advance.
  task automatic step(input bit v, input logic [PKT_HEAD_WIDTH-1:0] h,
                      input logic [PKT_DATA_WIDTH-1:0] d, input bit s, input bit l,
                      input bit ordy, output bit acc);
    bit     exp_ready, exp_valid, pop, err_next, first;
    mbeat_t b;
    bus.i_pkt_valid = v;
    bus.iv_pkt_head = h;
    bus.iv_pkt_data = d;
    bus.i_pkt_start = s;
    bus.i_pkt_last  = l;
    bus.i_out_ready = ordy;
    #1;
    exp_ready = rdy_ok && (out_q.size() + pend_q.size() < DD) && (heads < HD || !s || in_pkt);
`ifdef PKT_EGRESS_CUT_THROUGH_EN
    exp_valid = (out_q.size() != 0) && (heads != 0);
`else
    exp_valid = (pkts != 0);
`endif
    b = exp_valid ? out_q[0] : '0;
    chk("pkt_ready", 64'(bus.o_pkt_ready), 64'(exp_ready));
    chk("out_valid", 64'(bus.o_out_valid), 64'(exp_valid));
    chk("out_head",  64'(bus.ov_out_head), 64'(b.head));
    chk("out_data",  64'(bus.ov_out_data), 64'(b.data));
    chk("out_start", 64'(bus.o_out_start), 64'(b.start));
    chk("out_last",  64'(bus.o_out_last),  64'(b.last));
    chk("frame_err", 64'(bus.o_frame_err), 64'(exp_err));
    chk("pkt_cnt",   64'(bus.ov_pkt_cnt),  64'(pkts));

    pop      = exp_valid && ordy;
    acc      = v && exp_ready;
    err_next = 1'b0;
    if (pop) begin
      b = out_q.pop_front();
      if (b.last) begin
        heads--;
        pkts--;
      end
    end
    if (acc) begin
      if (!in_pkt && !s) begin
        err_next = 1'b1;
      end else begin
        first = !in_pkt;
        if (first) begin
          cur_head = h;
          heads++;
        end else if (s) begin
          err_next = 1'b1;
        end
        b = '{head: cur_head, data: d, start: first, last: l};
`ifdef PKT_EGRESS_CUT_THROUGH_EN
        out_q.push_back(b);
`else
        pend_q.push_back(b);
        if (l) while (pend_q.size() != 0) out_q.push_back(pend_q.pop_front());
`endif
        if (l) begin
          pkts++;
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
    end
    exp_err = err_next;
    @(negedge clk);
    rdy_ok = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_pkt_valid = 1'b0;
    bus.i_pkt_start = 1'b0;
    bus.i_pkt_last  = 1'b0;
    bus.i_out_ready = 1'b0;
    bus.iv_pkt_head = '0;
    bus.iv_pkt_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_pkt_ready), 64'(0));
    chk("rst_valid", 64'(bus.o_out_valid), 64'(0));
    chk("rst_bus",   64'({bus.ov_out_head, bus.o_out_start, bus.o_out_last}), 64'(0));
    chk("rst_data",  64'(bus.ov_out_data), 64'(0));
    chk("rst_err",   64'(bus.o_frame_err), 64'(0));
    chk("rst_cnt",   64'(bus.ov_pkt_cnt),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n, input int omode);
    bit acc;
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, ordy_of(omode), acc);
  endtask

  // Sends n beats, holding each until accepted; bad_mid forces start=1 on that beat index.
  task automatic send_pkt(input logic [PKT_HEAD_WIDTH-1:0] h, input int n,
                          input logic [PKT_DATA_WIDTH-1:0] base, input int omode,
                          input int gap_pct, input int bad_mid);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      acc   = 1'b0;
      tries = 0;
      while (!acc) begin
        if (int'($urandom_range(99)) < gap_pct)
          step(1'b0, '0, '0, 1'b0, 1'b0, ordy_of(omode), acc);
        else
          step(1'b1, h, base + PKT_DATA_WIDTH'(i), (i == 0) || (i == bad_mid),
               (i == n - 1), ordy_of(omode), acc);
        tries++;
        if (tries > 400) begin
          chk("send_timeout", 64'(acc), 64'(1));
          return;
        end
      end
    end
  endtask

  initial begin
    bit acc;
    int len;
    int r;
    model_clear();
    do_reset();

    // 4-beat packet, head A5, data 1..4, link always ready.
    send_pkt(8'hA5, 4, 32'd1, 1, 0, -1);
    idle(6, 1);

    // 64-beat packet with link stalled: fills the data FIFO, then stalls a new start.
    send_pkt(8'h3C, 64, 32'h100, 0, 0, -1);
    step(1'b1, 8'h11, 32'h999, 1'b1, 1'b1, 1'b0, acc);
    idle(70, 1);

    // Nine 1-beat packets, link stalled: ninth start beat held off by head FIFO.
    for (int k = 0; k < 8; k++) send_pkt(PKT_HEAD_WIDTH'(k + 1), 1, PKT_DATA_WIDTH'(k), 0, 0, -1);
    repeat (3) step(1'b1, 8'h09, 32'h8, 1'b1, 1'b1, 1'b0, acc);
    send_pkt(8'h09, 1, 32'h8, 1, 0, -1);
    idle(12, 1);

    // Headless beat while idle: swallowed with an error pulse.
    step(1'b1, 8'h33, 32'hDEAD, 1'b0, 1'b0, 1'b1, acc);
    idle(3, 1);

    // Reset in mid-packet, then a clean 2-beat packet.
    step(1'b1, 8'h77, 32'h1, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 8'h77, 32'h2, 1'b0, 1'b0, 1'b1, acc);
    do_reset();
    send_pkt(8'h5A, 2, 32'hA0, 1, 0, -1);
    idle(5, 1);

    // Randomized traffic with occasional framing faults.
    repeat (300) begin
      r = int'($urandom_range(99));
      if (r < 4) begin
        step(1'b1, PKT_HEAD_WIDTH'($urandom), PKT_DATA_WIDTH'($urandom), 1'b0,
             1'($urandom_range(1)), ordy_of(2), acc);
      end else begin
        len = (r < 12) ? int'($urandom_range(24, 9)) : int'($urandom_range(6, 1));
        send_pkt(PKT_HEAD_WIDTH'($urandom), len, PKT_DATA_WIDTH'($urandom), 2, 20,
                 (r < 9 && len > 2) ? 1 : -1);
      end
    end
    idle(250, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
